// File: rtl/riscv_register_file_mp.sv
// Parametrised multi-port register file with busy scoreboard and optional read bypass.
// Optional word parity is enabled by defining RF_PARITY_EN.
module riscv_register_file_mp #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int FPU          = 0,
    parameter int ZFINX        = 0,
    parameter int N_RPORTS     = 3,
    parameter int N_WPORTS     = 2,
    parameter int WRITE_BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           test_en_i,
    input  logic [N_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [N_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [N_RPORTS-1:0]            rbusy_o,
    input  logic [N_WPORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [N_WPORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [N_WPORTS-1:0]            we_i,
    input  logic                           rsv_req_i,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
    output logic                           rsv_gnt_o,
    input  logic                           par_inj_i,
    output logic [N_RPORTS-1:0]            perr_o
);

    localparam bit TWO_BANKS = (FPU != 0) && (ZFINX == 0);
    localparam int NUM_SLOTS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK = {1'b0, {(ADDR_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH-1:0] mem_reg [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  busy_reg;

    // With a single bank the bank-select bit folds onto the integer bank.
    function automatic logic [ADDR_WIDTH-1:0] phys_addr(input logic [ADDR_WIDTH-1:0] a);
        return TWO_BANKS ? a : (a & IDX_MASK);
    endfunction

    logic [ADDR_WIDTH-1:0] wphys [N_WPORTS];
    logic [N_WPORTS-1:0]   wvalid;
    logic [ADDR_WIDTH-1:0] rsv_phys;

    generate
        for (genvar gi = 0; gi < N_WPORTS; gi++) begin : g_wport
            assign wphys[gi]  = phys_addr(waddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]);
            assign wvalid[gi] = we_i[gi] && (wphys[gi] != '0);
        end
    endgenerate

    assign rsv_phys  = phys_addr(rsv_addr_i);
    assign rsv_gnt_o = rsv_req_i & ~busy_reg[rsv_phys];

    // Ascending port order makes the highest-index port win a collision;
    // the reservation set comes last so it beats a same-cycle write clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int p = 0; p < N_WPORTS; p++) begin
                if (wvalid[p]) begin
                    mem_reg[wphys[p]]  <= wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    busy_reg[wphys[p]] <= 1'b0;
                end
            end
            if (rsv_gnt_o && (rsv_phys != '0)) begin
                busy_reg[rsv_phys] <= 1'b1;
            end
        end
    end

`ifdef RF_PARITY_EN
    logic [NUM_SLOTS-1:0] par_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_reg <= '0;
        end else begin
            for (int p = 0; p < N_WPORTS; p++) begin
                if (wvalid[p]) begin
                    par_reg[wphys[p]] <= (^wdata_i[p*DATA_WIDTH +: DATA_WIDTH]) ^ par_inj_i;
                end
            end
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < N_RPORTS; gi++) begin : g_rport
            logic [ADDR_WIDTH-1:0] rphys;
            logic [DATA_WIDTH-1:0] rd_next;
            logic                  rb_next;
            logic                  pe_next;

            always_comb begin
                rphys   = phys_addr(raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]);
                rd_next = mem_reg[rphys];
                rb_next = busy_reg[rphys];
`ifdef RF_PARITY_EN
                pe_next = ^{mem_reg[rphys], par_reg[rphys]};
`else
                pe_next = 1'b0;
`endif
                if (rphys == '0) begin
                    rd_next = '0;
                    pe_next = 1'b0;
                end
                if (WRITE_BYPASS != 0) begin
                    for (int p = 0; p < N_WPORTS; p++) begin
                        if (wvalid[p] && (wphys[p] == rphys)) begin
                            rd_next = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                            rb_next = 1'b0;
                            pe_next = 1'b0;
                        end
                    end
                end
            end

            assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_next;
            assign rbusy_o[gi] = rb_next;
            assign perr_o[gi]  = pe_next;
        end
    endgenerate

    logic unused_ok;
    assign unused_ok = ^{test_en_i, par_inj_i};

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Directed bench: four register-file builds (bypass, no bypass, split FP bank, Zfinx) share stimulus.
module tb_riscv_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_en = 1'b0;
    logic [17:0] raddr;
    logic [63:0] wdata;
    logic [11:0] waddr;
    logic [1:0]  we;
    logic        rsv_req;
    logic [5:0]  rsv_addr;
    logic        par_inj;

    logic [95:0] rdata_a, rdata_b, rdata_c, rdata_d;
    logic [2:0]  rbusy_a, rbusy_b, rbusy_c, rbusy_d;
    logic        gnt_a, gnt_b, gnt_c, gnt_d;
    logic [2:0]  perr_a, perr_b, perr_c, perr_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_register_file_mp dut_a (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
        .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .rsv_gnt_o(gnt_a),
        .par_inj_i(par_inj), .perr_o(perr_a)
    );

    riscv_register_file_mp #(.WRITE_BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
        .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .rsv_gnt_o(gnt_b),
        .par_inj_i(par_inj), .perr_o(perr_b)
    );

    riscv_register_file_mp #(.FPU(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
        .raddr_i(raddr), .rdata_o(rdata_c), .rbusy_o(rbusy_c),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .rsv_gnt_o(gnt_c),
        .par_inj_i(par_inj), .perr_o(perr_c)
    );

    riscv_register_file_mp #(.FPU(1), .ZFINX(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
        .raddr_i(raddr), .rdata_o(rdata_d), .rbusy_o(rbusy_d),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .rsv_gnt_o(gnt_d),
        .par_inj_i(par_inj), .perr_o(perr_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic idle();
        we      = '0;
        wdata   = '0;
        waddr   = '0;
        rsv_req = 1'b0;
        par_inj = 1'b0;
    endtask

    task automatic set_w(input int p, input logic [5:0] a, input logic [31:0] d);
        waddr[p*6 +: 6]  = a;
        wdata[p*32 +: 32] = d;
        we[p]            = 1'b1;
    endtask

    task automatic set_r(input int p, input logic [5:0] a);
        raddr[p*6 +: 6] = a;
    endtask

    // Inputs change just after a negedge; outputs are sampled 1 ns later, well away from posedge.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    logic par_exp;

    initial begin
        rst_n = 1'b0;
        raddr = '0;
        rsv_addr = '0;
        idle();
        #3;
        check("reset_rdata_p0", rdata_a[31:0], 32'h0);
        check("reset_rbusy", {29'd0, rbusy_a}, 32'h0);
        check("reset_gnt", {31'd0, gnt_a}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Same-cycle bypass vs. next-cycle visibility.
        set_w(0, 6'd5, 32'hDEADBEEF);
        set_r(1, 6'd5);
        #1;
        check("bypass_x5", rdata_a[63:32], 32'hDEADBEEF);
        check("nobypass_x5_old", rdata_b[63:32], 32'h0);
        next_cycle();
        #1;
        check("nobypass_x5_new", rdata_b[63:32], 32'hDEADBEEF);
        check("bypass_x5_stored", rdata_a[63:32], 32'hDEADBEEF);

        // Write collision: highest-index port wins.
        set_w(0, 6'd7, 32'h1111);
        set_w(1, 6'd7, 32'h2222);
        set_r(0, 6'd7);
        #1;
        check("collide_bypass_x7", rdata_a[31:0], 32'h2222);
        next_cycle();
        #1;
        check("collide_stored_x7", rdata_b[31:0], 32'h2222);

        // x0 discards writes.
        set_w(0, 6'd0, 32'hFFFF);
        set_r(0, 6'd0);
        #1;
        check("x0_bypass", rdata_a[31:0], 32'h0);
        next_cycle();
        #1;
        check("x0_stored", rdata_a[31:0], 32'h0);

        // Banks: x3 = 0x33, then write f3 (6'h23) = 0xA5.
        set_w(0, 6'd3, 32'h33);
        next_cycle();
        set_w(0, 6'h23, 32'hA5);
        next_cycle();
        set_r(0, 6'd3);
        set_r(1, 6'h23);
        #1;
        check("fpu_x3", rdata_c[31:0], 32'h33);
        check("fpu_f3", rdata_c[63:32], 32'hA5);
        check("zfinx_x3", rdata_d[31:0], 32'hA5);
        check("nofpu_x3", rdata_a[31:0], 32'hA5);

        // Scoreboard.
        rsv_req  = 1'b1;
        rsv_addr = 6'd9;
        set_r(2, 6'd9);
        #1;
        check("rsv_x9_gnt", {31'd0, gnt_a}, 32'h1);
        check("rsv_x9_busy_before", {31'd0, rbusy_a[2]}, 32'h0);
        next_cycle();
        rsv_req  = 1'b1;
        rsv_addr = 6'd9;
        #1;
        check("rsv_x9_again_gnt", {31'd0, gnt_a}, 32'h0);
        check("rsv_x9_busy", {31'd0, rbusy_a[2]}, 32'h1);
        next_cycle();
        set_w(1, 6'd9, 32'h42);
        #1;
        check("wb_x9_bypass_busy", {31'd0, rbusy_a[2]}, 32'h0);
        check("wb_x9_nobypass_busy", {31'd0, rbusy_b[2]}, 32'h1);
        check("wb_x9_bypass_data", rdata_a[95:64], 32'h42);
        next_cycle();
        #1;
        check("wb_x9_cleared", {31'd0, rbusy_b[2]}, 32'h0);

        rsv_req  = 1'b1;
        rsv_addr = 6'd10;
        set_w(0, 6'd10, 32'h42);
        set_r(2, 6'd10);
        #1;
        check("rsv_wr_x10_gnt", {31'd0, gnt_a}, 32'h1);
        next_cycle();
        #1;
        check("rsv_wr_x10_busy", {31'd0, rbusy_a[2]}, 32'h1);
        check("rsv_wr_x10_data", rdata_b[95:64], 32'h42);

        rsv_req  = 1'b1;
        rsv_addr = 6'd0;
        set_r(1, 6'd0);
        #1;
        check("rsv_x0_gnt", {31'd0, gnt_a}, 32'h1);
        next_cycle();
        #1;
        check("rsv_x0_busy", {31'd0, rbusy_a[1]}, 32'h0);

        // Mid-stream asynchronous reset.
        set_r(0, 6'd5);
        set_r(1, 6'd7);
        set_r(2, 6'd10);
        #1;
        check("pre_reset_x5", rdata_a[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("midreset_x5", rdata_a[31:0], 32'h0);
        check("midreset_x7", rdata_b[63:32], 32'h0);
        check("midreset_busy_x10", {29'd0, rbusy_a}, 32'h0);
        check("midreset_gnt", {31'd0, gnt_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Parity injection.
`ifdef RF_PARITY_EN
        par_exp = 1'b1;
`else
        par_exp = 1'b0;
`endif
        set_w(0, 6'd4, 32'h1);
        par_inj = 1'b1;
        set_r(0, 6'd4);
        #1;
        check("par_bypass_perr", {31'd0, perr_a[0]}, 32'h0);
        next_cycle();
        #1;
        check("par_inj_perr", {31'd0, perr_a[0]}, {31'd0, par_exp});
        check("par_inj_data", rdata_a[31:0], 32'h1);
        set_w(0, 6'd4, 32'h1);
        next_cycle();
        #1;
        check("par_clean_perr", {31'd0, perr_a[0]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_register_file_mp.md
Name: riscv_register_file_mp

Overview:
Parametrised multi-port register file for the RI5CY core, successor to the fixed 3R/2W file. Read and write port counts and data width are parameters. Integer and FP banks can be separate or shared (Zfinx). Adds a per-register busy scoreboard for long-latency writebacks (LSU, FPU, div), write-collision priority and selectable read-during-write bypass. Sits in the ID stage; writes come from EX/WB, reservations come from the issue logic.

Parameters:
ADDR_WIDTH, 6, register address width; MSB selects the FP bank, bits [ADDR_WIDTH-2:0] are the index
DATA_WIDTH, 32, register width
FPU, 0, 1 = FP bank present
ZFINX, 0, 1 = FP operands live in the integer bank (no FP bank, address MSB ignored)
N_RPORTS, 3, number of read ports (1..4)
N_WPORTS, 2, number of write ports (1..3)
WRITE_BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
test_en_i  in  1  test mode; no functional effect, kept for interface compatibility
raddr_i  in  N_RPORTS*ADDR_WIDTH  read addresses; port p = slice p
rdata_o  out  N_RPORTS*DATA_WIDTH  read data
rbusy_o  out  N_RPORTS  addressed register has a write pending
waddr_i  in  N_WPORTS*ADDR_WIDTH  write addresses
wdata_i  in  N_WPORTS*DATA_WIDTH  write data
we_i  in  N_WPORTS  write enables
rsv_req_i  in  1  reservation request (issue of a long-latency op)
rsv_addr_i  in  ADDR_WIDTH  destination to reserve
rsv_gnt_o  out  1  reservation granted
par_inj_i  in  1  parity fault injection (only used with the optional feature)
perr_o  out  N_RPORTS  parity error on the read port

Behaviour:
Clock and reset:
- Single clock clk; reset rst_n is asynchronous and active-low.
- Reset, including mid-operation: all storage words = 0, all busy bits = 0, stored parity = 0. Consequences: rdata_o = 0, rbusy_o = 0, rsv_gnt_o = 0, perr_o = 0.

Banks:
- NUM_WORDS = 2**(ADDR_WIDTH-1) per bank.
- Two banks when FPU=1 and ZFINX=0; otherwise one bank and the address MSB is ignored.

Integer register 0:
- Reads return 0.
- Writes are discarded.
- Never busy; a reservation of it is granted with no effect.
- FP register 0 is normal storage.

Writes:
- Take effect on the rising clk edge.
- If several enabled ports target the same register, the highest-index port wins.

Reads:
- Combinational, zero latency.
- WRITE_BYPASS=1: if an enabled write hits the read address this cycle, rdata_o = that write's data (highest-index port wins). Otherwise the stored value.
- WRITE_BYPASS=0: always the stored value; new data is visible the next cycle.

Scoreboard:
- rsv_gnt_o = rsv_req_i & !busy[rsv_addr_i], combinational.
- Grant sets busy for that register on the next edge.
- Any enabled write to a register clears its busy bit on the next edge.
- Reservation and write to the same register in the same cycle (only possible when not busy): data is written and busy is set.
- rbusy_o[p] = busy[raddr_p], except with WRITE_BYPASS=1 it reads 0 when a same-cycle write hits raddr_p.
- Writes to non-busy registers are legal and leave busy at 0.

Optional Feature:
Macro RF_PARITY_EN:
- Defined: each word stores an even-parity bit, computed on write and inverted when par_inj_i=1.
- perr_o[p] = parity mismatch of the stored word addressed by port p, combinational. It is 0 for integer register 0 and for bypassed reads.
- Undefined: no parity storage; perr_o tied to 0; par_inj_i ignored.

Test Plan:
- Reset: pulse rst_n low mid-stream after writes -> every port immediately reads 0, rbusy_o=0, rsv_gnt_o=0.
- Write/read, WRITE_BYPASS=1: write 0xDEADBEEF to x5 on port 0 while port 1 reads x5 -> same-cycle rdata=0xDEADBEEF. Repeat with WRITE_BYPASS=0 -> old value, then 0xDEADBEEF next cycle.
- Collision and x0: ports 0 and 1 write x7 = 0x1111 / 0x2222 -> x7 reads 0x2222; write 0xFFFF to x0 -> x0 reads 0.
- Banks (FPU=1, ZFINX=0): write 0xA5 to addr 6'h23 (f3) -> x3 unchanged, f3=0xA5. With ZFINX=1 the same write -> x3=0xA5.
- Scoreboard: reserve x9 -> gnt=1, then rbusy=1; second reserve x9 -> gnt=0; write x9=0x42 -> rbusy clears next cycle (same cycle with bypass); reserve and write the same register in one cycle -> busy=1, data 0x42.
- With RF_PARITY_EN: write x4=0x1 with par_inj_i=1 -> reading x4 gives perr=1; rewrite with par_inj_i=0 -> perr=0.
